// File: rtl/utopia_phy_tx.sv
// UTOPIA Level 1 PHY-side cell source: buffers 52-byte host cells, inserts the HEC,
// and plays 53-byte cells to the ATM layer under its active-low read enable.
module utopia_phy_tx #(
  parameter int NumCells = 4,
  parameter int HecEn    = 1,
  parameter int CntW     = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic            wr_sop,
  input  logic [7:0]      wr_data,
  output logic            wr_full,
  output logic            wr_err,
  output logic [7:0]      data,
  output logic            soc,
  input  logic            en,
  output logic            clav,
  output logic [CntW-1:0] cells_sent,
  output logic [CntW-1:0] cells_dropped,
  output logic            rd_state
);

  localparam int SlotW = $clog2(NumCells);
  localparam int CntBW = $clog2(NumCells) + 1;

  typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} rd_state_e;

  logic [7:0]       mem_q [NumCells][53];
  logic [SlotW-1:0] wr_slot_q, wr_slot_d;
  logic [SlotW-1:0] rd_slot_q, rd_slot_d;
  logic [5:0]       wc_q, wc_d;
  logic [5:0]       rb_q, rb_d;
  logic [7:0]       hec_q, hec_d;
  logic [CntBW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0]  sent_q, sent_d;
  logic [CntW-1:0]  dropped_q, dropped_d;
  logic             err_q, err_d;
  rd_state_e        state_q, state_d;

  logic       full, accept, start, wr_byte, abort, commit, free;
  logic [5:0] byte_idx, wr_off;
  logic [7:0] crc_next, hec_byte;

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      r = {r[6:0], 1'b0} ^ ((r[7] ^ d[i]) ? 8'h07 : 8'h00);
    end
    return r;
  endfunction

  // Write side: wc_q is the index of the next expected byte; zero means no cell in progress.
  always_comb begin
    full      = (cnt_q == CntBW'(NumCells));
    accept    = wr_en && !full;
    start     = accept && wr_sop;
    wr_byte   = start || (accept && (wc_q != 6'd0));
    byte_idx  = start ? 6'd0 : wc_q;
    abort     = start && (wc_q != 6'd0);
    commit    = wr_byte && (byte_idx == 6'd51);
    wr_off    = (byte_idx < 6'd4) ? byte_idx : byte_idx + 6'd1;
    crc_next  = crc8((byte_idx == 6'd0) ? 8'h00 : hec_q, wr_data);
    hec_byte  = (HecEn != 0) ? (crc_next ^ 8'h55) : 8'h00;
    wc_d      = wc_q;
    hec_d     = hec_q;
    wr_slot_d = wr_slot_q;
    if (wr_byte) begin
      wc_d = commit ? 6'd0 : byte_idx + 6'd1;
      if (byte_idx < 6'd4) hec_d = crc_next;
      if (commit) wr_slot_d = wr_slot_q + 1'b1;
    end
    err_d     = abort || (wr_en && full);
    dropped_d = (abort || (wr_en && wr_sop && full)) ? dropped_q + CntW'(1) : dropped_q;
  end

  // Read handshake: while a cell is presented, every rising edge with en=0 consumes the
  // current byte; en=1 holds data/soc. In IDLE, en=0 with a buffered cell starts a cell.
  always_comb begin
    state_d   = state_q;
    rb_d      = rb_q;
    rd_slot_d = rd_slot_q;
    free      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!en && (cnt_q != '0)) begin
          state_d = S_SEND;
          rb_d    = 6'd0;
        end
      end
      S_SEND: begin
        if (!en) begin
          if (rb_q == 6'd52) begin
            free      = 1'b1;
            rb_d      = 6'd0;
            rd_slot_d = rd_slot_q + 1'b1;
            if (!((cnt_q >= CntBW'(2)) || commit)) state_d = S_IDLE;
          end else begin
            rb_d = rb_q + 6'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    cnt_d  = cnt_q;
    if (commit && !free) cnt_d = cnt_q + CntBW'(1);
    if (free && !commit) cnt_d = cnt_q - CntBW'(1);
    sent_d = free ? sent_q + CntW'(1) : sent_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      rb_q      <= 6'd0;
      rd_slot_q <= '0;
      wr_slot_q <= '0;
      wc_q      <= 6'd0;
      hec_q     <= 8'h00;
      cnt_q     <= '0;
      sent_q    <= '0;
      dropped_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rb_q      <= rb_d;
      rd_slot_q <= rd_slot_d;
      wr_slot_q <= wr_slot_d;
      wc_q      <= wc_d;
      hec_q     <= hec_d;
      cnt_q     <= cnt_d;
      sent_q    <= sent_d;
      dropped_q <= dropped_d;
      err_q     <= err_d;
    end
  end

  // Cell storage is not reset; stale bytes are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (wr_byte) begin
      mem_q[wr_slot_q][wr_off] <= wr_data;
      if (byte_idx == 6'd3) mem_q[wr_slot_q][4] <= hec_byte;
    end
  end

  assign data          = (state_q == S_SEND) ? mem_q[rd_slot_q][rb_q] : 8'h00;
  assign soc           = (state_q == S_SEND) && (rb_q == 6'd0);
  assign clav          = (state_q == S_SEND) ? (cnt_q >= CntBW'(2)) : (cnt_q != '0);
  assign wr_full       = full;
  assign wr_err        = err_q;
  assign cells_sent    = sent_q;
  assign cells_dropped = dropped_q;
  assign rd_state      = state_q;

endmodule
